// File: rtl/neo_frame_sequencer.sv
// rtl/neo_frame_sequencer.sv - frame buffer and load/send sequencer for an RGB pixel strand
// Optional auto-refresh enabled by defining NEO_AUTO_REFRESH_EN.
module neo_frame_sequencer #(
    parameter int NUM_PIXELS     = 5,
    parameter int REFRESH_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_pixel,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_level,
    input  logic       commit,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       load_color,
    output logic       send_it,
    input  logic       ready_to_load,
    input  logic       ready_to_send
);
    localparam int ENTRIES = NUM_PIXELS * 3;
    localparam int IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t      r_state;
    logic [2:0]  r_pix;
    logic [1:0]  r_col;
    logic        r_pending;
    logic        r_wait_first;
    logic        r_frame_done;
    logic [7:0]  r_buf [ENTRIES];

    logic          w_wr_ok;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_last;
    logic          w_refresh_tick;
    logic          w_start;

    assign w_wr_ok  = wr_en && ({1'b0, wr_pixel} < 4'(NUM_PIXELS)) && (wr_color != 2'd3);
    assign w_wr_idx = IW'(5'(wr_pixel) * 5'd3 + 5'(wr_color));
    assign w_rd_idx = IW'(5'(r_pix) * 5'd3 + 5'(r_col));
    assign w_last   = (r_pix == 3'(NUM_PIXELS - 1)) && (r_col == 2'd2);
    assign w_start  = commit || r_pending || w_refresh_tick;

`ifdef NEO_AUTO_REFRESH_EN
    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    logic [CW-1:0] r_refresh_cnt;

    // Held at zero outside IDLE, so every IDLE visit counts from zero.
    always_ff @(posedge clock) begin
        if (reset || r_state != S_IDLE || commit || w_refresh_tick)
            r_refresh_cnt <= '0;
        else
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end

    assign w_refresh_tick = (r_state == S_IDLE) && (r_refresh_cnt == CW'(REFRESH_CYCLES - 1));
`else
    assign w_refresh_tick = (REFRESH_CYCLES < 0);
`endif

    // Reads are combinational off the registers, so a same-cycle write loads the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) r_buf[i] <= '0;
        end else if (w_wr_ok) begin
            r_buf[w_wr_idx] <= wr_level;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pix        <= '0;
            r_col        <= '0;
            r_pending    <= 1'b0;
            r_wait_first <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (commit && r_state != S_IDLE) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_LOAD;
                        r_pix     <= '0;
                        r_col     <= '0;
                        r_pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ready_to_load) begin
                        if (w_last) begin
                            r_state <= S_SEND;
                        end else if (r_col == 2'd2) begin
                            r_col <= '0;
                            r_pix <= r_pix + 3'd1;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (ready_to_send) begin
                        r_state      <= S_WAIT;
                        r_wait_first <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (ready_to_load) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign load_color  = (r_state == S_LOAD) && ready_to_load;
    assign send_it     = (r_state == S_SEND) && ready_to_send;
    assign pixel_index = (r_state == S_LOAD) ? r_pix : 3'd0;
    assign color_index = (r_state == S_LOAD) ? r_col : 2'd0;
    assign color_level = (r_state == S_LOAD) ? r_buf[w_rd_idx] : 8'd0;
endmodule

// File: doc/neo_frame_sequencer.md
NEO_FRAME_SEQUENCER -- requirements
Module: neo_frame_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, default 5: pixels in strand, range 1..8.
REQ-002 Parameter REFRESH_CYCLES, default 750000: auto-refresh period in clocks (15 ms at 50 MHz).
REQ-003 clock  in  1  system clock, 50 MHz; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  host write strobe into frame buffer.
REQ-006 wr_pixel  in  3  host write pixel index.
REQ-007 wr_color  in  2  host write color index: 0, 1, 2 valid; 3 invalid.
REQ-008 wr_level  in  8  host write intensity.
REQ-009 commit  in  1  request to transmit the frame buffer.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-012 pixel_index  out  3  strand controller pixel select.
REQ-013 color_index  out  2  strand controller color select.
REQ-014 color_level  out  8  strand controller intensity.
REQ-015 load_color  out  1  strand controller load strobe.
REQ-016 send_it  out  1  strand controller transmit strobe.
REQ-017 ready_to_load  in  1  strand controller can accept load_color.
REQ-018 ready_to_send  in  1  strand controller can accept send_it.

Function
REQ-019 Frame buffer: NUM_PIXELS x 3 entries x 8 bits; write occurs on a clock edge with wr_en=1, wr_pixel<NUM_PIXELS and wr_color!=3; other writes are dropped silently.
REQ-020 Writes are accepted in every state; a same-cycle write and load of one entry sends the old value and stores the new one.
REQ-021 FSM states: IDLE, LOAD, SEND, WAIT.
REQ-022 IDLE->LOAD when a start condition exists (commit, pending flag, or refresh tick); the entry cursor is set to pixel 0, color 0.
REQ-023 LOAD: load_color = ready_to_load (combinational); pixel_index, color_index and color_level present the cursor entry throughout LOAD.
REQ-024 Each cycle with load_color=1 advances the cursor color 0->1->2, then wraps to color 0 with pixel+1; with ready_to_load held high, a full frame takes exactly 3*NUM_PIXELS cycles.
REQ-025 A load of pixel NUM_PIXELS-1, color 2 moves LOAD->SEND.
REQ-026 SEND: send_it = ready_to_send (combinational); a cycle with send_it=1 moves to WAIT.
REQ-027 WAIT: ready_to_load is ignored in the first WAIT cycle; the first later cycle with ready_to_load=1 pulses frame_done and moves to IDLE.
REQ-028 Outside LOAD, pixel_index, color_index and color_level hold 0; load_color is 0 outside LOAD; send_it is 0 outside SEND.
REQ-029 commit while busy sets a pending flag; multiple commits coalesce into one flag.
REQ-030 The pending flag clears on IDLE->LOAD, so a new frame starts the cycle after frame_done.
REQ-031 commit in the same cycle as frame_done is captured as pending.

Reset
REQ-032 Reset in any state forces IDLE on the next edge and clears the pending flag, cursor, refresh counter and all frame-buffer entries to 0.
REQ-033 Reset also forces busy, frame_done, load_color, send_it, pixel_index, color_index and color_level to 0.
REQ-034 A reset mid-frame abandons the frame; no frame_done is produced for it.

Configuration
REQ-035 Macro NEO_AUTO_REFRESH_EN defined: a counter runs in IDLE only; it is cleared on entry to IDLE and by commit.
REQ-036 When the counter reaches REFRESH_CYCLES-1, it raises a refresh tick that starts a frame exactly like commit.
REQ-037 Macro NEO_AUTO_REFRESH_EN undefined: no counter exists and frames start only on commit or pending.

Verification
REQ-038 Write pixel 2, color 1, level 0x5A, then commit, with both ready inputs held high -> 15 consecutive load_color cycles; the load with pixel_index=2, color_index=1 shows color_level=0x5A and all others show 0; one send_it; frame_done after ready_to_load returns.
REQ-039 ready_to_load toggles 1,0,1,0 during LOAD -> the cursor advances only on high cycles; indices and level hold steady across low cycles.
REQ-040 Three commits during LOAD -> exactly one further frame, starting the cycle after the first frame_done.
REQ-041 Writes with wr_color=3 and with wr_pixel=6 -> the next frame loads all levels as 0.
REQ-042 reset asserted during SEND -> all outputs 0 next cycle, no frame_done, buffer reads 0 on the next frame.
REQ-043 With NEO_AUTO_REFRESH_EN defined and REFRESH_CYCLES=20 -> a frame starts 20 cycles after frame_done with no commit; with the macro undefined, no frame starts.
